// File: rtl/pb_gesture_decoder.sv
// Push-button gesture classifier: turns debounced press/release events into
// single/double click, long press and auto-repeat pulses for downstream control FSMs.
module pb_gesture_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic PB_pressed_status,
  input  logic PB_pressed_pulse,
  input  logic PB_released_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam int MAX_LG  = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] LONG_END = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] REP_END  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  typedef struct packed {
    logic single_click;
    logic double_click;
    logic long_press;
    logic repeat_tick;
  } evt_t;

  state_t        state;
  logic [CW-1:0] cnt;
  evt_t          evt;

  // A release pulse always masks a coincident press pulse (illegal from the debouncer).
  logic press_ev, rel_ev;
  assign rel_ev   = PB_released_pulse;
  assign press_ev = PB_pressed_pulse & ~PB_released_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      evt   <= '0;
    end else begin
      evt <= '0;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (press_ev) state <= PRESS1;
        end
        PRESS1: begin
          if (rel_ev) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt == LONG_END) begin
            state          <= HOLD;
            cnt            <= '0;
            evt.long_press <= 1'b1;
          end else if (!PB_pressed_status) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        GAP: begin
          if (press_ev) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == GAP_END) begin
            state            <= IDLE;
            cnt              <= '0;
            evt.single_click <= 1'b1;
          end
        end
        PRESS2: begin
          if (rel_ev) begin
            state            <= IDLE;
            cnt              <= '0;
            evt.double_click <= 1'b1;
          end else if (cnt == LONG_END) begin
            state          <= HOLD;
            cnt            <= '0;
            evt.long_press <= 1'b1;
          end else if (!PB_pressed_status) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (rel_ev || !PB_pressed_status) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == REP_END) begin
            cnt             <= '0;
            evt.repeat_tick <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign single_click = evt.single_click;
  assign double_click = evt.double_click;
  assign long_press   = evt.long_press;
  assign repeat_tick  = evt.repeat_tick;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// Directed bench for pb_gesture_decoder: table of per-cycle vectors plus
// hand-written asynchronous reset sequences.
module tb_pb_gesture_decoder;

  logic clk = 1'b0;
  logic rst;
  logic pb_status, pb_press, pb_rel;
  logic single_click, double_click, long_press, repeat_tick, busy;

  always #5 clk = ~clk;

  pb_gesture_decoder #(
    .LONG_CYCLES  (20),
    .GAP_CYCLES   (10),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .PB_pressed_status(pb_status),
    .PB_pressed_pulse (pb_press),
    .PB_released_pulse(pb_rel),
    .single_click     (single_click),
    .double_click     (double_click),
    .long_press       (long_press),
    .repeat_tick      (repeat_tick),
    .busy             (busy)
  );

  // Output encoding: {single, double, long, tick, busy}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] B  = 5'b00001;
  localparam logic [4:0] SC = 5'b10000;
  localparam logic [4:0] DC = 5'b01000;
  localparam logic [4:0] LP = 5'b00101;
  localparam logic [4:0] RT = 5'b00011;

  typedef struct {
    string      tag;
    logic       p;
    logic       r;
    logic       s;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [4:0] outs;
  assign outs = {single_click, double_click, long_press, repeat_tick, busy};

  // n cycles of the given inputs; exp is the output vector in the following cycle.
  task automatic add(input string tag, input int n, input logic p, r, s, input logic [4:0] e);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.tag = tag; v.p = p; v.r = r; v.s = s; v.exp = e;
      vecs.push_back(v);
    end
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sc,dc,lp,rt,busy}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic p, r, s);
    pb_press = p; pb_rel = r; pb_status = s;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; pb_status = 1'b0; pb_press = 1'b0; pb_rel = 1'b0;

    // single click: press t0, release t0+5, single at t0+16
    add("single_press", 1, 1, 0, 1, B);
    add("single_hold",  4, 0, 0, 1, B);
    add("single_rel",   1, 0, 1, 0, B);
    add("single_gap",   9, 0, 0, 0, B);
    add("single_fire",  1, 0, 0, 0, SC);
    add("single_after", 3, 0, 0, 0, Z);
    // double click: press t0, rel t0+5, press t0+9, rel t0+14, double at t0+15
    add("dbl_press1",   1, 1, 0, 1, B);
    add("dbl_hold1",    4, 0, 0, 1, B);
    add("dbl_rel1",     1, 0, 1, 0, B);
    add("dbl_gap",      3, 0, 0, 0, B);
    add("dbl_press2",   1, 1, 0, 1, B);
    add("dbl_hold2",    4, 0, 0, 1, B);
    add("dbl_fire",     1, 0, 1, 0, DC);
    add("dbl_no_sc",   12, 0, 0, 0, Z);
    // long press held 40 cycles: long at t0+21, ticks t0+26/31/36
    add("long_press",   1, 1, 0, 1, B);
    add("long_hold",   19, 0, 0, 1, B);
    add("long_fire",    1, 0, 0, 1, LP);
    add("rep_wait1",    4, 0, 0, 1, B);
    add("rep_tick1",    1, 0, 0, 1, RT);
    add("rep_wait2",    4, 0, 0, 1, B);
    add("rep_tick2",    1, 0, 0, 1, RT);
    add("rep_wait3",    4, 0, 0, 1, B);
    add("rep_tick3",    1, 0, 0, 1, RT);
    add("rep_wait4",    4, 0, 0, 1, B);
    add("hold_rel",     1, 0, 1, 0, Z);
    add("hold_after",   8, 0, 0, 0, Z);
    // release coincides with cnt==19 in PRESS1, then press coincides with gap timeout
    add("coin_press",   1, 1, 0, 1, B);
    add("coin_hold",   19, 0, 0, 1, B);
    add("coin_rel",     1, 0, 1, 0, B);
    add("coin_gap",     9, 0, 0, 0, B);
    add("coin_press2",  1, 1, 0, 1, B);
    add("coin_hold2",   3, 0, 0, 1, B);
    add("coin_dbl",     1, 0, 1, 0, DC);
    add("coin_after",   3, 0, 0, 0, Z);
    // level drops without a release pulse in PRESS1
    add("lost_press",   1, 1, 0, 1, B);
    add("lost_hold",    2, 0, 0, 1, B);
    add("lost_drop",    1, 0, 0, 0, Z);
    add("lost_after",  12, 0, 0, 0, Z);
    // illegal simultaneous press+release in IDLE: release wins, nothing starts
    add("both_idle",    1, 1, 1, 1, Z);
    add("both_after",   2, 0, 0, 0, Z);

    // reset state
    repeat (2) @(posedge clk);
    #1 check("reset_state", outs, Z);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", outs, Z);

    foreach (vecs[i]) begin
      cyc(vecs[i].p, vecs[i].r, vecs[i].s);
      check(vecs[i].tag, outs, vecs[i].exp);
    end

    // async reset in the cycle long_press is high
    cyc(1, 0, 1);
    repeat (19) cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("rsthold_lp", outs, LP);
    #3 rst = 1'b0;
    #1 check("rsthold_async", outs, Z);
    pb_status = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0);
      check("rsthold_quiet", outs, Z);
    end

    // async reset while waiting in GAP: the pending single click is discarded
    cyc(1, 0, 1);
    repeat (4) cyc(0, 0, 1);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    check("rstgap_busy", outs, B);
    #3 rst = 1'b0;
    #1 check("rstgap_async", outs, Z);
    #2 rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cyc(0, 0, 0);
      check("rstgap_no_sc", outs, Z);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_gesture_decoder.md
Name: pb_gesture_decoder

Overview:
- Consumes the clean, synchronous button events from the push-button debouncer stage and classifies each user gesture as a single click, double click or long press.
- While a long press is held, issues periodic auto-repeat ticks.
- All outputs are registered single-cycle pulses for the control FSMs downstream (menu/counter logic).

Parameters:
- LONG_CYCLES, 50_000_000: hold duration in clk cycles that qualifies a press as long; must be >= 2.
- GAP_CYCLES, 25_000_000: maximum release-to-press gap in clk cycles for a second press to count as a double click; must be >= 2.
- REPEAT_CYCLES, 10_000_000: repeat_tick period in clk cycles during a long hold; must be >= 2.

Ports:
- clk  input  1  base clock, same domain as the debouncer.
- rst  input  1  asynchronous, active-low reset. Asserted when 0.
- PB_pressed_status  input  1  debounced button level.
- PB_pressed_pulse  input  1  1-cycle pulse on a debounced press.
- PB_released_pulse  input  1  1-cycle pulse on a debounced release.
- single_click  output  1  1-cycle pulse.
- double_click  output  1  1-cycle pulse.
- long_press  output  1  1-cycle pulse when the long threshold is reached.
- repeat_tick  output  1  1-cycle pulse every REPEAT_CYCLES while a long hold continues.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - rst=0 forces state=IDLE, cnt=0 and all outputs to 0 immediately (asynchronous).
  - Reset mid-gesture discards the gesture; no event is emitted after reset release.
- Counter:
  - Single cnt register, width $clog2(max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)).
  - Cleared on every state change; otherwise increments by 1 in PRESS1, GAP, PRESS2 and HOLD.
  - Never wraps: each state exits or clears cnt at its terminal value.
- States and transitions (evaluated on posedge clk):
  - IDLE:
    - PB_pressed_pulse -> PRESS1.
    - PB_released_pulse is ignored.
  - PRESS1:
    - PB_released_pulse -> GAP.
    - Else if cnt == LONG_CYCLES-1 -> HOLD, with long_press=1 next cycle.
    - Else if PB_pressed_status==0 (lost release) -> IDLE, no event.
  - GAP:
    - PB_pressed_pulse -> PRESS2.
    - Else if cnt == GAP_CYCLES-1 -> IDLE, with single_click=1 next cycle.
  - PRESS2:
    - PB_released_pulse -> IDLE, with double_click=1 next cycle.
    - Else if cnt == LONG_CYCLES-1 -> HOLD, with long_press=1; no double_click and no single_click is emitted for this gesture.
    - Else if PB_pressed_status==0 -> IDLE, no event.
  - HOLD:
    - PB_released_pulse or PB_pressed_status==0 -> IDLE, no event.
    - Else when cnt == REPEAT_CYCLES-1: repeat_tick=1 next cycle and cnt <= 0.
    - The first repeat_tick is REPEAT_CYCLES cycles after long_press.
- Latency:
  - Every output pulse is registered and asserts exactly 1 cycle after the clock edge that makes the decision.
  - single_click therefore appears GAP_CYCLES+1 cycles after the release pulse.
- Simultaneous events:
  - If a release pulse and a terminal count occur in the same cycle of PRESS1/PRESS2, the release wins (treated as a short press).
  - If a press pulse and the GAP timeout coincide, the press wins (PRESS2).
  - Press and release pulses asserted together (illegal from the debouncer): release has priority.
- Mutual exclusion: at most one of single_click, double_click, long_press, repeat_tick is high in any cycle.
- A third rapid press after a double click starts a new gesture from IDLE.

Test Plan (LONG_CYCLES=20, GAP_CYCLES=10, REPEAT_CYCLES=5):
- Press pulse at t0, release at t0+5, no further press -> single_click high exactly at t0+5+11; no other outputs; busy falls the same cycle.
- Press at t0, release t0+5, press t0+9, release t0+14 -> double_click high at t0+15; single_click never asserts.
- Press at t0, held 40 cycles -> long_press at t0+21, repeat_tick at t0+26, t0+31, t0+36; release -> no further pulses, busy=0.
- Release pulse and cnt==19 in the same cycle of PRESS1 -> GAP entered, no long_press; press-pulse/timeout coincidence in GAP -> PRESS2.
- rst=0 asserted mid-HOLD and in GAP, asynchronously between clock edges -> all outputs 0 and busy=0 before the next edge; no single_click after reset release.
- PB_pressed_status drops with no release pulse in PRESS1 -> IDLE, no event.
